// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants, field indices and state type for the FP adder normalize/round stage
package fp_pkg;
  localparam int EXP_WIDTH      = 8;
  localparam int MANTISSA_WIDTH = 23;
  localparam int BIAS           = (1 << (EXP_WIDTH - 1)) - 1;
  localparam int EXP_ALL_ONES   = (1 << EXP_WIDTH) - 1;

  localparam int CARRY_BIT  = MANTISSA_WIDTH + 4;
  localparam int HIDDEN_BIT = MANTISSA_WIDTH + 3;
  localparam int FRAC_LSB   = 3;
  localparam int G_BIT      = 2;
  localparam int R_BIT      = 1;
  localparam int S_BIT      = 0;

  localparam logic [EXP_WIDTH+MANTISSA_WIDTH:0] CANON_NAN =
    {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANTISSA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - combinational round-to-nearest-even on {hidden, fraction} with g/r/s
module fp_round_rne #(
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic [MANTISSA_WIDTH:0] i_sig,
  input  logic                    i_guard,
  input  logic                    i_round,
  input  logic                    i_sticky,
  output logic [MANTISSA_WIDTH:0] o_sig,
  output logic                    o_carry,
  output logic                    o_inexact
);
  logic                      w_round_up;
  logic [MANTISSA_WIDTH+1:0] w_sum;

  // ties go up only when the kept lsb is odd
  assign w_round_up = i_guard & (i_round | i_sticky | i_sig[0]);
  assign w_sum      = {1'b0, i_sig} + {{(MANTISSA_WIDTH+1){1'b0}}, w_round_up};
  assign o_sig      = w_sum[MANTISSA_WIDTH:0];
  assign o_carry    = w_sum[MANTISSA_WIDTH+1];
  assign o_inexact  = i_guard | i_round | i_sticky;
endmodule

// File: rtl/fpa_normalize_round.sv
// rtl/fpa_normalize_round.sv - iterative normalizer plus RNE rounder producing packed IEEE-754 results
module fpa_normalize_round #(
  parameter int EXP_WIDTH      = fp_pkg::EXP_WIDTH,
  parameter int MANTISSA_WIDTH = fp_pkg::MANTISSA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_sign,
  input  logic [EXP_WIDTH-1:0]              in_exp,
  input  logic [MANTISSA_WIDTH+4:0]         in_mant,
  input  logic                              in_is_nan,
  input  logic                              in_is_inf,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0] out_result,
  output logic                              out_overflow,
  output logic                              out_underflow,
  output logic                              out_inexact
);
  import fp_pkg::*;

  localparam int EW = EXP_WIDTH;
  localparam int MW = MANTISSA_WIDTH;
  localparam int XW = MW + 5;
  localparam int CB = MW + 4;
  localparam int HB = MW + 3;
  localparam int RW = EW + MW + 1;
  localparam logic [EW:0]   EXP_ONE  = {{EW{1'b0}}, 1'b1};
  localparam logic [EW:0]   EXP_SAT  = {1'b0, {EW{1'b1}}};
  localparam logic [RW-1:0] NAN_WORD = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  state_t        r_state, w_state_next;
  logic          r_sign, r_nan, r_inf;
  logic [EW:0]   r_exp, w_exp_next;
  logic [XW-1:0] r_mant, w_mant_next;
  logic [RW-1:0] r_result, w_result;
  logic          r_overflow, r_underflow, r_inexact;
  logic          w_overflow, w_underflow, w_inexact;

  logic [MW:0]   w_round_sig;
  logic          w_round_carry, w_round_inexact;
  logic [EW:0]   w_exp_rounded;
  logic [MW-1:0] w_frac_rounded;
  logic          w_mant_zero;

  fp_round_rne #(.MANTISSA_WIDTH(MW)) u_round (
    .i_sig     (r_mant[HB:FRAC_LSB]),
    .i_guard   (r_mant[G_BIT]),
    .i_round   (r_mant[R_BIT]),
    .i_sticky  (r_mant[S_BIT]),
    .o_sig     (w_round_sig),
    .o_carry   (w_round_carry),
    .o_inexact (w_round_inexact)
  );

  assign w_mant_zero    = (r_mant == '0);
  assign w_exp_rounded  = r_exp + {{EW{1'b0}}, w_round_carry};
  // a rounding carry-out leaves {1, 0...0}; shifting right keeps the top fraction bits
  assign w_frac_rounded = w_round_carry ? w_round_sig[MW:1] : w_round_sig[MW-1:0];

  always_comb begin
    w_state_next = r_state;
    w_exp_next   = r_exp;
    w_mant_next  = r_mant;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_next = ST_NORM;
          w_exp_next   = {1'b0, in_exp};
          w_mant_next  = in_mant;
        end
      end
      ST_NORM: begin
        if (r_nan || r_inf || w_mant_zero) begin
          w_state_next = ST_ROUND;
        end else if (r_mant[CB]) begin
          w_mant_next = {1'b0, r_mant[XW-1:2], r_mant[1] | r_mant[0]};
          w_exp_next  = r_exp + EXP_ONE;
        end else if (!r_mant[HB] && (r_exp > EXP_ONE)) begin
          w_mant_next = {r_mant[XW-2:0], 1'b0};
          w_exp_next  = r_exp - EXP_ONE;
        end else begin
          w_state_next = ST_ROUND;
        end
      end
      ST_ROUND: w_state_next = ST_DONE;
      ST_DONE:  if (out_ready) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_result    = '0;
    w_overflow  = 1'b0;
    w_underflow = 1'b0;
    w_inexact   = 1'b0;
    if (r_nan) begin
      w_result = NAN_WORD;
    end else if (r_inf) begin
      w_result = {r_sign, {EW{1'b1}}, {MW{1'b0}}};
    end else if (w_mant_zero) begin
      w_result = {r_sign, {(RW-1){1'b0}}};
    end else if (!r_mant[HB]) begin
      w_result    = {r_sign, {(RW-1){1'b0}}};
      w_underflow = 1'b1;
      w_inexact   = w_round_inexact;
    end else if (w_exp_rounded >= EXP_SAT) begin
      w_result   = {r_sign, {EW{1'b1}}, {MW{1'b0}}};
      w_overflow = 1'b1;
      w_inexact  = w_round_inexact;
    end else begin
      w_result  = {r_sign, w_exp_rounded[EW-1:0], w_frac_rounded};
      w_inexact = w_round_inexact;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sign      <= 1'b0;
      r_nan       <= 1'b0;
      r_inf       <= 1'b0;
      r_exp       <= '0;
      r_mant      <= '0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_inexact   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_exp   <= w_exp_next;
      r_mant  <= w_mant_next;
      if (r_state == ST_IDLE && in_valid) begin
        r_sign <= in_sign;
        r_nan  <= in_is_nan;
        r_inf  <= in_is_inf;
      end
      if (r_state == ST_ROUND) begin
        r_result    <= w_result;
        r_overflow  <= w_overflow;
        r_underflow <= w_underflow;
        r_inexact   <= w_inexact;
      end
    end
  end

  assign in_ready      = (r_state == ST_IDLE) && !rst;
  assign out_valid     = (r_state == ST_DONE);
  assign out_result    = r_result;
  assign out_overflow  = r_overflow;
  assign out_underflow = r_underflow;
  assign out_inexact   = r_inexact;
endmodule
